spart_core: RTL and testbench

SPART_CORE -- requirements
Module: spart_core

---
 rtl/spart_pkg.sv | 24 ++
 rtl/spart_baud_gen.sv | 23 ++
 rtl/spart_core.sv | 200 ++++++++++++++++++++
 tb/tb_spart_core.sv | 170 +++++++++++++++++
 4 files changed

// File: rtl/spart_pkg.sv
// SPART shared constants: register map, FSM encodings, divisor presets.
package spart_pkg;

  localparam logic [1:0] ADDR_BUF    = 2'b00;
  localparam logic [1:0] ADDR_STATUS = 2'b01;
  localparam logic [1:0] ADDR_DBL    = 2'b10;
  localparam logic [1:0] ADDR_DBH    = 2'b11;

  localparam int OVERSAMPLE_DEF = 16;

  localparam logic [15:0] DIV_4800  = 16'h0516;
  localparam logic [15:0] DIV_9600  = 16'h028B;
  localparam logic [15:0] DIV_19200 = 16'h0146;
  localparam logic [15:0] DIV_38400 = 16'h00A3;

  typedef enum logic [1:0] {
    TX_IDLE, TX_START, TX_DATA, TX_STOP
  } tx_state_e;

  typedef enum logic [1:0] {
    RX_IDLE, RX_START, RX_DATA, RX_STOP
  } rx_state_e;

endpackage

// File: rtl/spart_baud_gen.sv
// Baud enable generator: one-clock pulse every divisor clocks.
module spart_baud_gen (
  input  logic        clk,
  input  logic        rst,
  input  logic [15:0] divisor,
  input  logic        clr,
  output logic        en
);

  logic [15:0] cnt;

  // divisor 0 or 1 degenerates to an enable on every clock
  always_comb begin
    en = (divisor <= 16'd1) || (cnt == divisor - 16'd1);
  end

  always_ff @(posedge clk) begin
    if (rst || clr) cnt <= '0;
    else if (en)    cnt <= '0;
    else            cnt <= cnt + 16'd1;
  end

endmodule

// File: rtl/spart_core.sv
// SPART: bus-mapped UART with programmable divisor,
// oversampled receiver and status flags.
module spart_core
  import spart_pkg::*;
#(
  parameter int          OVERSAMPLE = OVERSAMPLE_DEF,
  parameter logic [15:0] DIV_RESET  = 16'h0516
) (
  input  logic       clk,
  input  logic       rst,
  input  logic       iocs,
  input  logic       iorw,
  input  logic [1:0] ioaddr,
  inout  wire  [7:0] databus,
  output logic       rda,
  output logic       tbr,
  output logic       txd,
  input  logic       rxd
);

  localparam int OSW = (OVERSAMPLE > 1) ? $clog2(OVERSAMPLE) : 1;
  localparam logic [OSW-1:0] OS_LAST = OSW'(OVERSAMPLE - 1);
  localparam logic [OSW-1:0] OS_HALF = OSW'(OVERSAMPLE / 2 - 1);

  logic        wr, rd;
  logic        wr_buf, wr_dbl, wr_dbh;
  logic        rd_buf, rd_stat;
  logic [15:0] divisor;
  logic        en;
  logic [7:0]  rd_data;

  assign wr      = iocs & ~iorw;
  assign rd      = iocs & iorw;
  assign wr_buf  = wr && (ioaddr == ADDR_BUF);
  assign wr_dbl  = wr && (ioaddr == ADDR_DBL);
  assign wr_dbh  = wr && (ioaddr == ADDR_DBH);
  assign rd_buf  = rd && (ioaddr == ADDR_BUF);
  assign rd_stat = rd && (ioaddr == ADDR_STATUS);

  always_ff @(posedge clk) begin
    if (rst) begin
      divisor <= DIV_RESET;
    end else begin
      if (wr_dbl) divisor[7:0]  <= databus;
      if (wr_dbh) divisor[15:8] <= databus;
    end
  end

  spart_baud_gen u_baud (
    .clk     (clk),
    .rst     (rst),
    .divisor (divisor),
    .clr     (wr_dbl | wr_dbh),
    .en      (en)
  );

  // ---------------- transmitter ----------------
  tx_state_e      tx_state, tx_next;
  logic [OSW-1:0] tx_os;
  logic [2:0]     tx_bit;
  logic [7:0]     tx_buf;
  logic           tx_last;

  assign tx_last = en && (tx_os == OS_LAST);

  always_ff @(posedge clk) begin
    if (rst) tx_state <= TX_IDLE;
    else     tx_state <= tx_next;
  end

  always_comb begin
    tx_next = tx_state;
    unique case (tx_state)
      TX_IDLE:  if (en && !tbr) tx_next = TX_START;
      TX_START: if (tx_last) tx_next = TX_DATA;
      TX_DATA:  if (tx_last && tx_bit == 3'd7) tx_next = TX_STOP;
      TX_STOP:  if (tx_last) tx_next = TX_IDLE;
    endcase
  end

  always_comb begin
    txd = 1'b1;
    unique case (tx_state)
      TX_START: txd = 1'b0;
      TX_DATA:  txd = tx_buf[0];
      default:  txd = 1'b1;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      tx_os  <= '0;
      tx_bit <= '0;
      tx_buf <= '0;
      tbr    <= 1'b1;
    end else begin
      if (tx_state == TX_IDLE || tx_last) tx_os <= '0;
      else if (en)                        tx_os <= tx_os + 1'b1;
      if (wr_buf && tbr) begin
        tx_buf <= databus;
        tbr    <= 1'b0;
      end
      if (tx_state == TX_START) tx_bit <= '0;
      if (tx_state == TX_DATA && tx_last) begin
        tx_buf <= {1'b0, tx_buf[7:1]};
        tx_bit <= tx_bit + 3'd1;
      end
      if (tx_state == TX_STOP && tx_last) tbr <= 1'b1;
    end
  end

  // ---------------- receiver ----------------
  rx_state_e      rx_state, rx_next;
  logic [1:0]     rx_sync;
  logic           rx_s, rx_prev;
  logic [OSW-1:0] rx_os;
  logic [2:0]     rx_bit;
  logic [7:0]     rx_shift, rx_buf;
  logic           rx_hit, rx_done, rx_ferr;
  logic           overrun, frame_err;

  assign rx_s    = rx_sync[1];
  assign rx_hit  = en && (rx_os == ((rx_state == RX_START) ? OS_HALF : OS_LAST));
  assign rx_done = (rx_state == RX_STOP) && rx_hit && rx_s;
  assign rx_ferr = (rx_state == RX_STOP) && rx_hit && !rx_s;

  always_ff @(posedge clk) begin
    if (rst) begin
      rx_sync <= 2'b11;
      rx_prev <= 1'b1;
    end else begin
      rx_sync <= {rx_sync[0], rxd};
      rx_prev <= rx_s;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) rx_state <= RX_IDLE;
    else     rx_state <= rx_next;
  end

  // a line that is high again at the half-bit point was a glitch
  always_comb begin
    rx_next = rx_state;
    unique case (rx_state)
      RX_IDLE:  if (rx_prev && !rx_s) rx_next = RX_START;
      RX_START: if (rx_hit) rx_next = rx_s ? RX_IDLE : RX_DATA;
      RX_DATA:  if (rx_hit && rx_bit == 3'd7) rx_next = RX_STOP;
      RX_STOP:  if (rx_hit) rx_next = RX_IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      rx_os    <= '0;
      rx_bit   <= '0;
      rx_shift <= '0;
    end else begin
      if (rx_state == RX_IDLE || rx_hit) rx_os <= '0;
      else if (en)                       rx_os <= rx_os + 1'b1;
      if (rx_state == RX_START) rx_bit <= '0;
      if (rx_state == RX_DATA && rx_hit) begin
        rx_shift <= {rx_s, rx_shift[7:1]};
        rx_bit   <= rx_bit + 3'd1;
      end
    end
  end

  // sets take priority over the clearing reads
  always_ff @(posedge clk) begin
    if (rst) begin
      rx_buf    <= '0;
      rda       <= 1'b0;
      overrun   <= 1'b0;
      frame_err <= 1'b0;
    end else begin
      if (rx_done) rx_buf <= rx_shift;
      if (rx_done)     rda <= 1'b1;
      else if (rd_buf) rda <= 1'b0;
      if (rx_done && rda && !rd_buf) overrun <= 1'b1;
      else if (rd_stat)              overrun <= 1'b0;
      if (rx_ferr)      frame_err <= 1'b1;
      else if (rd_stat) frame_err <= 1'b0;
    end
  end

  // ---------------- bus read ----------------
  always_comb begin
    rd_data = '0;
    unique case (ioaddr)
      ADDR_BUF:    rd_data = rx_buf;
      ADDR_STATUS: rd_data = {4'b0, frame_err, overrun, tbr, rda};
      ADDR_DBL:    rd_data = divisor[7:0];
      ADDR_DBH:    rd_data = divisor[15:8];
    endcase
  end

  assign databus = rd ? rd_data : 8'hzz;

endmodule

// File: tb/tb_spart_core.sv
// Directed bench for spart_core: register access,
// tx framing, rx, error flags, glitch and reset.
module tb_spart_core;
  import spart_pkg::*;

  localparam int BIT = 64;

  logic       clk = 1'b0;
  logic       rst = 1'b1;
  logic       iocs = 1'b0;
  logic       iorw = 1'b1;
  logic [1:0] ioaddr = 2'b00;
  logic       rxd = 1'b1;
  logic       bus_oe = 1'b0;
  logic [7:0] bus_drv = 8'h00;
  wire  [7:0] databus;
  logic       rda, tbr, txd;

  int checks = 0;
  int failures = 0;

  assign databus = bus_oe ? bus_drv : 8'hzz;

  always #5 clk = ~clk;

  spart_core dut (
    .clk     (clk),
    .rst     (rst),
    .iocs    (iocs),
    .iorw    (iorw),
    .ioaddr  (ioaddr),
    .databus (databus),
    .rda     (rda),
    .tbr     (tbr),
    .txd     (txd),
    .rxd     (rxd)
  );

  task automatic chk(input string tag, input logic [15:0] got,
                     input logic [15:0] exp);
    checks++;
    if (got !== exp) begin
      failures++;
      $display("FAIL %s got=%h exp=%h", tag, got, exp);
    end
  endtask

  task automatic bus_wr(input logic [1:0] a, input logic [7:0] d);
    @(negedge clk);
    iocs = 1'b1; iorw = 1'b0; ioaddr = a;
    bus_drv = d; bus_oe = 1'b1;
    @(posedge clk); #1;
    iocs = 1'b0; iorw = 1'b1; bus_oe = 1'b0;
  endtask

  task automatic bus_rd(input logic [1:0] a, output logic [7:0] d);
    @(negedge clk);
    iocs = 1'b1; iorw = 1'b1; ioaddr = a;
    #1 d = databus;
    @(posedge clk); #1;
    iocs = 1'b0;
  endtask

  task automatic send_byte(input logic [7:0] b, input logic stop);
    logic [9:0] f;
    f = {stop, b, 1'b0};
    for (int i = 0; i < 10; i++) begin
      rxd = f[i];
      repeat (BIT) @(posedge clk);
      #1;
    end
    rxd = 1'b1;
    repeat (2 * BIT) @(posedge clk);
    #1;
  endtask

  task automatic clocks(input int n);
    repeat (n) @(posedge clk);
    #1;
  endtask

  logic [7:0] rv;
  logic [9:0] frame;
  int         n;

  initial begin
    clocks(3);
    rst = 1'b0;
    clocks(1);
    chk("rst_txd", 16'(txd), 16'h1);
    chk("rst_tbr", 16'(tbr), 16'h1);
    chk("rst_rda", 16'(rda), 16'h0);
    bus_rd(ADDR_STATUS, rv); chk("rst_status", 16'(rv), 16'h02);
    bus_rd(ADDR_DBL, rv);    chk("rst_dbl", 16'(rv), 16'h16);
    bus_rd(ADDR_DBH, rv);    chk("rst_dbh", 16'(rv), 16'h05);

    // divisor 163 and enable period
    bus_wr(ADDR_DBL, 8'hA3);
    bus_wr(ADDR_DBH, 8'h00);
    bus_rd(ADDR_DBL, rv); chk("div_lo", 16'(rv), 16'h00A3);
    bus_rd(ADDR_DBH, rv); chk("div_hi", 16'(rv), 16'h0000);
    n = 0;
    @(negedge clk);
    while (!dut.u_baud.en && n < 1000) begin @(negedge clk); n++; end
    n = 0;
    @(negedge clk); n++;
    while (!dut.u_baud.en && n < 1000) begin @(negedge clk); n++; end
    chk("baud_period", 16'(n), 16'd163);

    // transmit 0x55 at divisor 4
    bus_wr(ADDR_DBL, 8'h04);
    bus_wr(ADDR_DBH, 8'h00);
    bus_wr(ADDR_BUF, 8'h55);
    chk("tx_tbr_low", 16'(tbr), 16'h0);
    n = 0;
    while (txd && n < 100) begin @(posedge clk); #1; n++; end
    chk("tx_start_seen", 16'(n < 100), 16'h1);
    bus_wr(ADDR_BUF, 8'hAA);
    clocks(31);
    frame = {1'b1, 8'h55, 1'b0};
    for (int i = 0; i < 10; i++) begin
      chk($sformatf("tx_bit%0d", i), 16'(txd), 16'(frame[i]));
      clocks(BIT);
    end
    chk("tx_tbr_done", 16'(tbr), 16'h1);

    // receive 0xC3
    send_byte(8'hC3, 1'b1);
    chk("rx_rda", 16'(rda), 16'h1);
    bus_rd(ADDR_BUF, rv); chk("rx_data", 16'(rv), 16'h00C3);
    chk("rx_rda_clr", 16'(rda), 16'h0);

    // overrun
    send_byte(8'h11, 1'b1);
    send_byte(8'h22, 1'b1);
    bus_rd(ADDR_STATUS, rv); chk("ovr_status", 16'(rv), 16'h07);
    bus_rd(ADDR_STATUS, rv); chk("ovr_cleared", 16'(rv), 16'h03);
    bus_rd(ADDR_BUF, rv);    chk("ovr_data", 16'(rv), 16'h22);
    bus_rd(ADDR_STATUS, rv); chk("ovr_after", 16'(rv), 16'h02);

    // framing error
    send_byte(8'h5A, 1'b0);
    bus_rd(ADDR_STATUS, rv); chk("ferr_status", 16'(rv), 16'h0A);
    bus_rd(ADDR_STATUS, rv); chk("ferr_cleared", 16'(rv), 16'h02);

    // short low glitch
    rxd = 1'b0;
    clocks(20);
    rxd = 1'b1;
    clocks(12 * BIT);
    chk("glitch_rda", 16'(rda), 16'h0);
    bus_rd(ADDR_STATUS, rv); chk("glitch_status", 16'(rv), 16'h02);

    // reset in the middle of a transmit
    bus_wr(ADDR_BUF, 8'h00);
    clocks(200);
    chk("mid_tx_low", 16'(txd), 16'h0);
    rst = 1'b1;
    clocks(1);
    rst = 1'b0;
    chk("rst_mid_txd", 16'(txd), 16'h1);
    chk("rst_mid_tbr", 16'(tbr), 16'h1);
    bus_rd(ADDR_DBL, rv); chk("rst_mid_dbl", 16'(rv), 16'h16);
    bus_rd(ADDR_DBH, rv); chk("rst_mid_dbh", 16'(rv), 16'h05);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
